adc_capture_sequencer: RTL

//  Schedules LTC2324-16 capture bursts for the AXI-DMA ADC datapath in the adc_clk domain.
//  - Arms on a software or external trigger and drives sample_start, sample_len and ch_sel.
//  - Holds sample_start until the datapath acknowledges with st_clr, then counts adc_data_valid to detect capture end.
//  - Repeats for cfg_burst_num captures, spaced by cfg_gap idle cycles; reports status and errors.

---
 rtl/adc_seq_pkg.sv | 15 +
 rtl/trig_sync_edge.sv | 26 ++
 rtl/adc_capture_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_seq_pkg.sv
// Shared state encoding and parameter defaults for the ADC capture sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RUN   = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4
  } seq_state_e;

  localparam int unsigned ACK_TIMEOUT_DEF = 64;
  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/trig_sync_edge.sv
// Multi-flop synchronizer for the asynchronous external trigger plus a rising-edge detector.
module trig_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic adc_clk,
  input  logic adc_rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/adc_capture_sequencer.sv
// Schedules capture bursts for the ADC datapath: start handshake, frame counting, inter-capture
// gaps, abort/drain handling and sticky error/status reporting.
module adc_capture_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic        adc_clk,
  input  logic        adc_rst,
  input  logic [31:0] cfg_sample_len,
  input  logic [7:0]  cfg_ch_sel,
  input  logic [15:0] cfg_burst_num,
  input  logic [31:0] cfg_gap,
  input  logic        cfg_trig_ext,
  input  logic        sw_start,
  input  logic        sw_abort,
  input  logic        ext_trig,
  input  logic        st_clr,
  input  logic        adc_data_valid,
  output logic        sample_start,
  output logic [31:0] sample_len,
  output logic [7:0]  ch_sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] capture_idx,
  output logic        err_timeout,
  output logic        err_cfg,
  output logic [7:0]  trig_overrun
);

  localparam int unsigned AckW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [AckW-1:0] AckMax = AckW'(ACK_TIMEOUT - 1);

  seq_state_e  state_q, state_d;
  logic        sample_start_q, sample_start_d;
  logic [31:0] sample_len_q, sample_len_d;
  logic [7:0]  ch_sel_q, ch_sel_d;
  logic [15:0] burst_q, burst_d;
  logic [31:0] gap_q, gap_d;
  logic [15:0] capture_idx_q, capture_idx_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
  logic        done_q, done_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_cfg_q, err_cfg_d;
  logic [7:0]  trig_overrun_q, trig_overrun_d;

  logic        ext_rise;
  logic        trig;
  logic [31:0] frame_next;
  logic        last_frame;
  logic        gap_expire;

  trig_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_trig_sync (
    .adc_clk  (adc_clk),
    .adc_rst  (adc_rst),
    .async_in (ext_trig),
    .rise     (ext_rise)
  );

  assign trig       = cfg_trig_ext ? ext_rise : sw_start;
  assign frame_next = frame_cnt_q + 32'd1;
  assign last_frame = adc_data_valid && (frame_next == sample_len_q);
  // A zero gap still spends one cycle in GAP before the next request.
  assign gap_expire = (gap_q == 32'd0) || (gap_cnt_q == gap_q - 32'd1);

  always_comb begin
    state_d        = state_q;
    sample_start_d = sample_start_q;
    sample_len_d   = sample_len_q;
    ch_sel_d       = ch_sel_q;
    burst_d        = burst_q;
    gap_d          = gap_q;
    capture_idx_d  = capture_idx_q;
    frame_cnt_d    = frame_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    ack_cnt_d      = ack_cnt_q;
    done_d         = 1'b0;
    err_timeout_d  = err_timeout_q;
    err_cfg_d      = err_cfg_q;
    trig_overrun_d = trig_overrun_q;

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          if (cfg_sample_len == 32'd0) begin
            err_cfg_d = 1'b1;
          end else begin
            sample_len_d   = cfg_sample_len;
            ch_sel_d       = cfg_ch_sel;
            burst_d        = cfg_burst_num;
            gap_d          = cfg_gap;
            capture_idx_d  = 16'd0;
            err_cfg_d      = 1'b0;
            err_timeout_d  = 1'b0;
            ack_cnt_d      = '0;
            sample_start_d = 1'b1;
            state_d        = REQ;
          end
        end
      end
      REQ: begin
        if (sw_abort) begin
          sample_start_d = 1'b0;
          state_d        = IDLE;
        end else if (st_clr) begin
          sample_start_d = 1'b0;
          frame_cnt_d    = 32'd0;
          state_d        = RUN;
        end else if (ack_cnt_q == AckMax) begin
          err_timeout_d  = 1'b1;
          sample_start_d = 1'b0;
          state_d        = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (adc_data_valid) begin
          frame_cnt_d = frame_next;
        end
        if (last_frame) begin
          if (sw_abort) begin
            state_d = IDLE;
          end else begin
            capture_idx_d = capture_idx_q + 16'd1;
            if ((burst_q != 16'd0) && (capture_idx_d == burst_q)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              gap_cnt_d = 32'd0;
              state_d   = GAP;
            end
          end
        end else if (sw_abort) begin
          state_d = DRAIN;
        end
      end
      GAP: begin
        if (sw_abort) begin
          state_d = IDLE;
        end else if (gap_expire) begin
          ack_cnt_d      = '0;
          sample_start_d = 1'b1;
          state_d        = REQ;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      DRAIN: begin
        if (adc_data_valid) begin
          frame_cnt_d = frame_next;
        end
        if (last_frame) begin
          state_d = IDLE;
        end
      end
      default: begin
        sample_start_d = 1'b0;
        state_d        = IDLE;
      end
    endcase

    if (ext_rise && (state_q != IDLE) && (trig_overrun_q != 8'hFF)) begin
      trig_overrun_d = trig_overrun_q + 8'd1;
    end
  end

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      state_q        <= IDLE;
      sample_start_q <= 1'b0;
      sample_len_q   <= 32'd0;
      ch_sel_q       <= 8'd0;
      burst_q        <= 16'd0;
      gap_q          <= 32'd0;
      capture_idx_q  <= 16'd0;
      frame_cnt_q    <= 32'd0;
      gap_cnt_q      <= 32'd0;
      ack_cnt_q      <= '0;
      done_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_cfg_q      <= 1'b0;
      trig_overrun_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      sample_start_q <= sample_start_d;
      sample_len_q   <= sample_len_d;
      ch_sel_q       <= ch_sel_d;
      burst_q        <= burst_d;
      gap_q          <= gap_d;
      capture_idx_q  <= capture_idx_d;
      frame_cnt_q    <= frame_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      ack_cnt_q      <= ack_cnt_d;
      done_q         <= done_d;
      err_timeout_q  <= err_timeout_d;
      err_cfg_q      <= err_cfg_d;
      trig_overrun_q <= trig_overrun_d;
    end
  end

  assign sample_start = sample_start_q;
  assign sample_len   = sample_len_q;
  assign ch_sel       = ch_sel_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign capture_idx  = capture_idx_q;
  assign err_timeout  = err_timeout_q;
  assign err_cfg      = err_cfg_q;
  assign trig_overrun = trig_overrun_q;

endmodule
